// File: rtl/vc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_rr_arbiter
// Function : strict-priority VC arbiter with round-robin port selection and
//            per-destination routing. Optional starvation guard for VC>0 is
//            built when ARB_STARVE_GUARD_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module vc_rr_arbiter #(
  parameter  int DATA_W       = 6,
  parameter  int NUM_PORTS    = 2,
  parameter  int NUM_VC       = 2,
  parameter  int NUM_DEST     = 2,
  parameter  int DEST_LSB     = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int DEST_W       = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1,
  localparam int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset_L,
  input  logic [NUM_VC*NUM_PORTS*DATA_W-1:0]   data_in,
  input  logic [NUM_VC*NUM_PORTS-1:0]          empty_in,
  input  logic [NUM_DEST-1:0]                  pause_in,
  output logic [NUM_VC*NUM_PORTS-1:0]          pop_out,
  output logic [NUM_DEST*(DATA_W+VC_W)-1:0]    data_out,
  output logic [NUM_DEST-1:0]                  valid_out
);

  localparam int NQ    = NUM_VC * NUM_PORTS;
  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int OUT_W = DATA_W + VC_W;

  logic [DATA_W-1:0]   w_head [NQ];
  logic [NQ-1:0]       w_req;
  logic [NUM_VC-1:0]   w_vc_any;
  logic [PTR_W-1:0]    w_pick [NUM_VC];
  logic [PTR_W-1:0]    r_ptr  [NUM_VC];
  logic                w_grant;
  logic [VC_W-1:0]     w_gvc;
  logic [PTR_W-1:0]    w_gport;
  logic [NQ-1:0]       w_pop;
  logic [DATA_W-1:0]   w_gword;
  logic [DEST_W-1:0]   w_gdest;
  logic [NUM_VC-1:0]   w_starved;
  logic [NUM_DEST-1:0] r_valid;
  logic [OUT_W-1:0]    r_data [NUM_DEST];

  if (NUM_PORTS < 2) begin : g_chk_ports
    $error("vc_rr_arbiter: NUM_PORTS must be at least 2");
  end
  if ((NUM_DEST & (NUM_DEST - 1)) != 0) begin : g_chk_dest
    $error("vc_rr_arbiter: NUM_DEST must be a power of 2");
  end
  if (DEST_LSB + DEST_W > DATA_W) begin : g_chk_field
    $error("vc_rr_arbiter: destination field exceeds DATA_W");
  end
  if (STARVE_LIMIT < 1) begin : g_chk_limit
    $error("vc_rr_arbiter: STARVE_LIMIT must be at least 1");
  end

  // A head is eligible only if its FIFO has data and its own destination is not paused.
  for (genvar i = 0; i < NQ; i++) begin : g_req
    logic [DEST_W-1:0] w_dest;
    assign w_head[i] = data_in[i*DATA_W +: DATA_W];
    assign w_dest    = w_head[i][DEST_LSB +: DEST_W];
    assign w_req[i]  = ~empty_in[i] & ~pause_in[w_dest];
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [NUM_PORTS-1:0] w_rq;
    logic                 w_any;
    logic [PTR_W-1:0]     w_sel;
    logic [PTR_W:0]       w_cand;
    assign w_rq = w_req[v*NUM_PORTS +: NUM_PORTS];
    always_comb begin
      w_any  = 1'b0;
      w_sel  = '0;
      w_cand = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_cand = {1'b0, r_ptr[v]} + (PTR_W+1)'(k);
        if (w_cand >= (PTR_W+1)'(NUM_PORTS)) begin
          w_cand = w_cand - (PTR_W+1)'(NUM_PORTS);
        end
        if (!w_any && w_rq[w_cand[PTR_W-1:0]]) begin
          w_any = 1'b1;
          w_sel = w_cand[PTR_W-1:0];
        end
      end
    end
    assign w_vc_any[v] = w_any;
    assign w_pick[v]   = w_sel;
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_wait [NUM_VC];

  // VC0 never needs a guard, so its counter is pinned at zero.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!reset_L || v == 0) begin
        r_wait[v] <= '0;
      end else if (w_grant && w_gvc == VC_W'(v)) begin
        r_wait[v] <= '0;
      end else if (w_vc_any[v] && r_wait[v] != CNT_W'(STARVE_LIMIT)) begin
        r_wait[v] <= r_wait[v] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_starved = '0;
    for (int v = 1; v < NUM_VC; v++) begin
      w_starved[v] = (r_wait[v] == CNT_W'(STARVE_LIMIT));
    end
  end
`else
  assign w_starved = '0;
`endif

  always_comb begin
    w_grant = 1'b0;
    w_gvc   = '0;
    for (int v = NUM_VC-1; v >= 0; v--) begin
      if (w_vc_any[v]) begin
        w_grant = 1'b1;
        w_gvc   = VC_W'(v);
      end
    end
    // A saturated wait counter lets its VC jump ahead; lowest such VC wins.
    for (int v = NUM_VC-1; v >= 0; v--) begin
      if (w_vc_any[v] && w_starved[v]) begin
        w_gvc = VC_W'(v);
      end
    end
    w_gport = w_pick[w_gvc];
    w_pop   = '0;
    w_gword = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_pop[v*NUM_PORTS+p] = w_grant && (w_gvc == VC_W'(v)) && (w_gport == PTR_W'(p));
        if (w_pop[v*NUM_PORTS+p]) begin
          w_gword = w_gword | w_head[v*NUM_PORTS+p];
        end
      end
    end
    w_gdest = w_gword[DEST_LSB +: DEST_W];
  end

  assign pop_out   = reset_L ? w_pop : '0;
  assign valid_out = r_valid;

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_out
    assign data_out[d*OUT_W +: OUT_W] = r_data[d];
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_valid <= '0;
      for (int d = 0; d < NUM_DEST; d++) begin
        r_data[d] <= '0;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        r_ptr[v] <= '0;
      end
    end else begin
      r_valid <= w_grant ? (NUM_DEST'(1) << w_gdest) : '0;
      if (w_grant) begin
        r_data[w_gdest] <= {w_gvc, w_gword};
        r_ptr[w_gvc]    <= (w_gport == PTR_W'(NUM_PORTS-1)) ? '0 : w_gport + PTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_rr_arbiter
// Function : self-checking bench for vc_rr_arbiter (directed scenarios plus a
//            randomized run against a queue-based reference model).
// Revision : 1.0  initial release
// ============================================================================
module tb_vc_rr_arbiter;

  localparam int DW   = 6;
  localparam int NP   = 2;
  localparam int NV   = 2;
  localparam int ND   = 2;
  localparam int DLSB = 4;
  localparam int DEW  = 1;
  localparam int VCW  = 1;
  localparam int SLIM = 8;
  localparam int NQ   = NV * NP;
  localparam int OW   = DW + VCW;

  logic             clk = 1'b0;
  logic             reset_L;
  logic [NQ*DW-1:0] data_in;
  logic [NQ-1:0]    empty_in;
  logic [ND-1:0]    pause_in;
  logic [NQ-1:0]    pop_out;
  logic [ND*OW-1:0] data_out;
  logic [ND-1:0]    valid_out;

  always #5 clk = ~clk;

  vc_rr_arbiter #(
    .DATA_W(DW), .NUM_PORTS(NP), .NUM_VC(NV), .NUM_DEST(ND),
    .DEST_LSB(DLSB), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .empty_in(empty_in),
    .pause_in(pause_in), .pop_out(pop_out), .data_out(data_out), .valid_out(valid_out)
  );

  int checks   = 0;
  int failures = 0;

  // Environment FIFOs (show-ahead) and reference-model state.
  logic [DW-1:0] q [NQ][$];
  int            m_ptr  [NV];
  int            m_cand [NV];
  int            m_wait [NV];
  logic [ND-1:0] m_valid;
  logic [OW-1:0] m_data [ND];

  task automatic apply_inputs();
    for (int i = 0; i < NQ; i++) begin
      if (q[i].size() > 0) begin
        data_in[i*DW +: DW] = q[i][0];
        empty_in[i]         = 1'b0;
      end else begin
        data_in[i*DW +: DW] = DW'($urandom);
        empty_in[i]         = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ptr[v]  = 0;
      m_wait[v] = 0;
      m_cand[v] = -1;
    end
    m_valid = '0;
    for (int d = 0; d < ND; d++) m_data[d] = '0;
  endtask

  // Which FIFO should be granted now, from the arbitration rules.
  function automatic int model_pick();
    int win;
    win = -1;
    for (int v = 0; v < NV; v++) begin
      m_cand[v] = -1;
      for (int k = 0; k < NP; k++) begin
        int i;
        i = v*NP + (m_ptr[v] + k) % NP;
        if (m_cand[v] < 0 && q[i].size() > 0 && !pause_in[q[i][0][DLSB +: DEW]]) m_cand[v] = i;
      end
    end
    for (int v = 0; v < NV; v++) if (win < 0 && m_cand[v] >= 0) win = m_cand[v];
`ifdef ARB_STARVE_GUARD_EN
    begin
      int s;
      s = -1;
      for (int v = 1; v < NV; v++) if (s < 0 && m_wait[v] >= SLIM && m_cand[v] >= 0) s = m_cand[v];
      if (s >= 0) win = s;
    end
`endif
    return win;
  endfunction

  task automatic model_commit(input int g);
    if (g >= 0) begin
      logic [DW-1:0] w;
      int v, p, d;
      w = q[g].pop_front();
      v = g / NP;
      p = g % NP;
      m_ptr[v]  = (p + 1) % NP;
      d         = int'(w[DLSB +: DEW]);
      m_valid   = ND'(1) << d;
      m_data[d] = {VCW'(v), w};
    end else begin
      m_valid = '0;
    end
    for (int v = 1; v < NV; v++) begin
      if (g >= 0 && g / NP == v) m_wait[v] = 0;
      else if (m_cand[v] >= 0 && m_wait[v] < SLIM) m_wait[v]++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_L  = 1'b0;
    pause_in = '0;
    for (int i = 0; i < NQ; i++) begin
      q[i].push_back(DW'($urandom));
      q[i].push_back(DW'($urandom));
    end
    apply_inputs();
    #1;
    checks++;
    if (pop_out !== '0) begin failures++; $display("FAIL reset_pop_entry got=%b exp=0", pop_out); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (pop_out !== '0) begin failures++; $display("FAIL reset_pop cyc=%0d got=%b exp=0", c, pop_out); end
      checks++;
      if (valid_out !== '0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, valid_out); end
      checks++;
      if (data_out !== '0) begin failures++; $display("FAIL reset_data cyc=%0d got=%h exp=0", c, data_out); end
    end
    for (int i = 0; i < NQ; i++) q[i].delete();
    apply_inputs();
    model_reset();
    reset_L = 1'b1;
  endtask

  task automatic test_rr_vc0();
    int            pops [8] = '{0, 1, 0, 1, 0, 1, -1, -1};
    logic [1:0]    vld  [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [13:0]   dout [8] = '{{7'h00,7'h00}, {7'h00,7'h01}, {7'h00,7'h0A}, {7'h00,7'h02},
                                {7'h00,7'h0B}, {7'h00,7'h03}, {7'h00,7'h0C}, {7'h00,7'h0C}};
    logic [NQ-1:0] ep;
    q[0].push_back(6'h01); q[0].push_back(6'h02); q[0].push_back(6'h03);
    q[1].push_back(6'h0A); q[1].push_back(6'h0B); q[1].push_back(6'h0C);
    pause_in = '0;
    for (int k = 0; k < 8; k++) begin
      apply_inputs();
      #1;
      ep = (pops[k] >= 0) ? (NQ'(1) << pops[k]) : '0;
      checks++;
      if (pop_out !== ep) begin failures++; $display("FAIL rr_pop cyc=%0d got=%b exp=%b", k, pop_out, ep); end
      checks++;
      if (valid_out !== vld[k]) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", k, valid_out, vld[k]); end
      checks++;
      if (data_out !== dout[k]) begin failures++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", k, data_out, dout[k]); end
      @(posedge clk);
      if (pops[k] >= 0) void'(q[pops[k]].pop_front());
      @(negedge clk);
    end
  endtask

  task automatic test_priority();
    int            pops [5] = '{1, 1, 2, -1, -1};
    logic [1:0]    vld  [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [13:0]   dout [5] = '{{7'h00,7'h0C}, {7'h00,7'h06}, {7'h00,7'h07}, {7'h00,7'h45}, {7'h00,7'h45}};
    logic [NQ-1:0] ep;
    q[1].push_back(6'h06); q[1].push_back(6'h07);
    q[2].push_back(6'h05);
    pause_in = '0;
    for (int k = 0; k < 5; k++) begin
      apply_inputs();
      #1;
      ep = (pops[k] >= 0) ? (NQ'(1) << pops[k]) : '0;
      checks++;
      if (pop_out !== ep) begin failures++; $display("FAIL prio_pop cyc=%0d got=%b exp=%b", k, pop_out, ep); end
      checks++;
      if (valid_out !== vld[k]) begin failures++; $display("FAIL prio_valid cyc=%0d got=%b exp=%b", k, valid_out, vld[k]); end
      checks++;
      if (data_out !== dout[k]) begin failures++; $display("FAIL prio_data cyc=%0d got=%h exp=%h", k, data_out, dout[k]); end
      @(posedge clk);
      if (pops[k] >= 0) void'(q[pops[k]].pop_front());
      @(negedge clk);
    end
  endtask

  task automatic test_dest_pause();
    int            pops [5] = '{1, -1, 0, -1, -1};
    logic [1:0]    pz   [5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0]    vld  [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [13:0]   dout [5] = '{{7'h00,7'h45}, {7'h00,7'h03}, {7'h00,7'h03}, {7'h15,7'h03}, {7'h15,7'h03}};
    logic [NQ-1:0] ep;
    q[0].push_back(6'b010101);
    q[1].push_back(6'h03);
    for (int k = 0; k < 5; k++) begin
      pause_in = pz[k];
      apply_inputs();
      #1;
      ep = (pops[k] >= 0) ? (NQ'(1) << pops[k]) : '0;
      checks++;
      if (pop_out !== ep) begin failures++; $display("FAIL pause_pop cyc=%0d got=%b exp=%b", k, pop_out, ep); end
      checks++;
      if (valid_out !== vld[k]) begin failures++; $display("FAIL pause_valid cyc=%0d got=%b exp=%b", k, valid_out, vld[k]); end
      checks++;
      if (data_out !== dout[k]) begin failures++; $display("FAIL pause_data cyc=%0d got=%h exp=%h", k, data_out, dout[k]); end
      @(posedge clk);
      if (pops[k] >= 0) void'(q[pops[k]].pop_front());
      @(negedge clk);
    end
  endtask

  task automatic test_mixed_routing();
    int            pops [6] = '{1, 0, 1, 0, -1, -1};
    logic [1:0]    vld  [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [13:0]   dout [6] = '{{7'h15,7'h03}, {7'h15,7'h04}, {7'h11,7'h04},
                                {7'h13,7'h04}, {7'h13,7'h02}, {7'h13,7'h02}};
    logic [NQ-1:0] ep;
    q[0].push_back(6'h11); q[0].push_back(6'h02);
    q[1].push_back(6'h04); q[1].push_back(6'h13);
    pause_in = '0;
    for (int k = 0; k < 6; k++) begin
      apply_inputs();
      #1;
      ep = (pops[k] >= 0) ? (NQ'(1) << pops[k]) : '0;
      checks++;
      if (pop_out !== ep) begin failures++; $display("FAIL mix_pop cyc=%0d got=%b exp=%b", k, pop_out, ep); end
      checks++;
      if (valid_out !== vld[k]) begin failures++; $display("FAIL mix_valid cyc=%0d got=%b exp=%b", k, valid_out, vld[k]); end
      checks++;
      if (data_out !== dout[k]) begin failures++; $display("FAIL mix_data cyc=%0d got=%h exp=%h", k, data_out, dout[k]); end
      @(posedge clk);
      if (pops[k] >= 0) void'(q[pops[k]].pop_front());
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int            g;
    logic [NQ-1:0] ep;
    logic [ND*OW-1:0] ed;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NQ; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 2) == 0) q[i].push_back(DW'($urandom));
      end
      for (int d = 0; d < ND; d++) pause_in[d] = ($urandom_range(0, 3) == 0);
      apply_inputs();
      #1;
      g  = model_pick();
      ep = (g >= 0) ? (NQ'(1) << g) : '0;
      for (int d = 0; d < ND; d++) ed[d*OW +: OW] = m_data[d];
      checks++;
      if (pop_out !== ep) begin failures++; $display("FAIL rand_pop cyc=%0d got=%b exp=%b", k, pop_out, ep); end
      checks++;
      if (valid_out !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", k, valid_out, m_valid); end
      checks++;
      if (data_out !== ed) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", k, data_out, ed); end
      @(posedge clk);
      model_commit(g);
      @(negedge clk);
    end
  endtask

`ifdef ARB_STARVE_GUARD_EN
  task automatic test_starve();
    int            g;
    logic [NQ-1:0] ep;
    logic [NQ-1:0] ex;
    for (int i = 0; i < 12; i++) begin
      q[0].push_back(DW'($urandom) & 6'h2F);
      q[1].push_back(DW'($urandom) & 6'h2F);
    end
    q[2].push_back(6'h2A);
    pause_in = '0;
    for (int k = 0; k < 12; k++) begin
      apply_inputs();
      #1;
      g  = model_pick();
      ep = (g >= 0) ? (NQ'(1) << g) : '0;
      if (k < 8)       ex = (k % 2) ? 4'b0010 : 4'b0001;
      else if (k == 8) ex = 4'b0100;
      else             ex = (k % 2) ? 4'b0001 : 4'b0010;
      checks++;
      if (pop_out !== ex) begin failures++; $display("FAIL starve_pop cyc=%0d got=%b exp=%b", k, pop_out, ex); end
      checks++;
      if (pop_out !== ep) begin failures++; $display("FAIL starve_model cyc=%0d got=%b exp=%b", k, pop_out, ep); end
      checks++;
      if (valid_out !== m_valid) begin failures++; $display("FAIL starve_valid cyc=%0d got=%b exp=%b", k, valid_out, m_valid); end
      @(posedge clk);
      model_commit(g);
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    reset_L  = 1'b0;
    pause_in = '0;
    data_in  = '0;
    empty_in = '1;
    model_reset();
    test_reset();
    test_rr_vc0();
    test_priority();
    test_dest_pause();
    test_mixed_routing();
    test_reset();
    test_random();
    test_reset();
`ifdef ARB_STARVE_GUARD_EN
    test_starve();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
